// File: rtl/mem_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_pkg
// Description : Shared definitions for the memory-address sequencer:
//               source-select encodings, FSM state type, default vector
//               table placement and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_addr_pkg;

    // Address source select encodings; 5..7 are reserved and hold mem_addr.
    localparam logic [2:0] SEL_PC         = 3'd0;
    localparam logic [2:0] SEL_ALU_RESULT = 3'd1;
    localparam logic [2:0] SEL_EXT16      = 3'd2;
    localparam logic [2:0] SEL_ALU_OUT    = 3'd3;
    localparam logic [2:0] SEL_EXT25      = 3'd4;

    // Vector-fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default vector table placement.
    localparam int unsigned C_VEC_BASE_DEFAULT = 253;
    localparam int unsigned C_NUM_VEC_DEFAULT  = 3;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_assembler.sv
`default_nettype none
// ============================================================================
// Module      : vec_assembler
// Description : Byte-lane register of VEC_BYTES lanes. A byte is written
//               into a selected lane; the lane set is zero-extended to an
//               ADDR_W word. o_word reflects the lanes including the write
//               happening this cycle, so the caller can register the
//               finished word on the same edge as the last byte.
// Ports       : clk, reset (async, active-low)
//               i_clear  - zero all lanes (wins over i_load)
//               i_load   - write i_data into lane i_lane
//               i_lane   - lane index, 0 = least significant byte
//               i_data   - byte to insert
//               o_word   - zero-extended next lane contents
// Revision    : 1.0 - initial release
// ============================================================================
module vec_assembler
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned VEC_BYTES = 1,
    parameter int unsigned LANE_W    = clog2_min1(VEC_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [7:0]        i_data,
    output logic [ADDR_W-1:0] o_word
);

    logic [VEC_BYTES-1:0][7:0] r_lanes;
    logic [VEC_BYTES-1:0][7:0] w_next;

    always_comb begin
        w_next = r_lanes;
        if (i_clear) begin
            w_next = '0;
        end else begin
            for (int i = 0; i < VEC_BYTES; i++) begin
                if (i_load && (i_lane == LANE_W'(i))) begin
                    w_next[i] = i_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lanes <= '0;
        end else begin
            r_lanes <= w_next;
        end
    end

    // Lanes fill from bit 0 upward; bits above 8*VEC_BYTES read as zero.
    assign o_word = ADDR_W'(w_next);

endmodule
`default_nettype wire

// File: rtl/mem_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_seq
// Description : Registered memory-address source for the multicycle CPU.
//               Selects PC / ALU result / ext16 / ALU-out / ext25 as the
//               next memory address, and sequences exception-vector fetches
//               from a multi-byte little-endian vector table.
// Ports       : clk, reset (async, active-low)
//               sel, pc, alu_result, ext16, alu_out, ext25 - address sources
//               exc_req, exc_cause - vector fetch request and index
//               mem_rdata          - byte read, one cycle after mem_addr
//               mem_addr           - registered memory address
//               busy               - vector fetch in progress
//               vec_valid          - one-cycle pulse, handler_addr updated
//               handler_addr       - assembled handler address
//               exc_err            - one-cycle pulse, cause out of range
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_seq
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned VEC_BASE  = C_VEC_BASE_DEFAULT,
    parameter int unsigned NUM_VEC   = C_NUM_VEC_DEFAULT,
    parameter int unsigned VEC_BYTES = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2:0]                      sel,
    input  logic [ADDR_W-1:0]               pc,
    input  logic [ADDR_W-1:0]               alu_result,
    input  logic [ADDR_W-1:0]               ext16,
    input  logic [ADDR_W-1:0]               alu_out,
    input  logic [ADDR_W-1:0]               ext25,
    input  logic                            exc_req,
    input  logic [clog2_min1(NUM_VEC)-1:0]  exc_cause,
    input  logic [7:0]                      mem_rdata,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic                            busy,
    output logic                            vec_valid,
    output logic [ADDR_W-1:0]               handler_addr,
    output logic                            exc_err
);

    localparam int unsigned CNT_W = clog2_min1(VEC_BYTES);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;          // index of the byte on mem_addr
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_handler;
    logic                r_exc_err;

    logic [ADDR_W-1:0]   w_mux_addr;
    logic [ADDR_W-1:0]   w_vec_addr;
    logic [ADDR_W-1:0]   w_asm_word;
    logic                w_cause_ok;
    logic                w_can_accept;
    logic                w_accept;
    logic                w_last;
    logic                w_lane_load;
    logic [CNT_W-1:0]    w_lane;

    // Reserved encodings fall through to the current address (hold).
    always_comb begin
        w_mux_addr = r_mem_addr;
        case (sel)
            SEL_PC:         w_mux_addr = pc;
            SEL_ALU_RESULT: w_mux_addr = alu_result;
            SEL_EXT16:      w_mux_addr = ext16;
            SEL_ALU_OUT:    w_mux_addr = alu_out;
            SEL_EXT25:      w_mux_addr = ext25;
            default:        w_mux_addr = r_mem_addr;
        endcase
    end

    // Vector entry address wraps modulo 2^ADDR_W.
    assign w_vec_addr   = ADDR_W'(VEC_BASE) + ADDR_W'(exc_cause) * ADDR_W'(VEC_BYTES);
    assign w_cause_ok   = 32'(exc_cause) < NUM_VEC;
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept     = w_can_accept && exc_req && w_cause_ok;
    assign w_last       = (r_cnt == CNT_W'(VEC_BYTES - 1));

    // Read data lags the address by one cycle, so in ISSUE the byte arriving
    // belongs to the previous counter value; DRAIN collects the final byte.
    assign w_lane_load  = (r_state == ST_DRAIN) || ((r_state == ST_ISSUE) && (r_cnt != '0));
    assign w_lane       = (r_state == ST_DRAIN) ? CNT_W'(VEC_BYTES - 1) : (r_cnt - CNT_W'(1));

    vec_assembler #(
        .ADDR_W    (ADDR_W),
        .VEC_BYTES (VEC_BYTES),
        .LANE_W    (CNT_W)
    ) u_vec_assembler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .i_load  (w_lane_load),
        .i_lane  (w_lane),
        .i_data  (mem_rdata),
        .o_word  (w_asm_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_handler  <= '0;
            r_exc_err  <= 1'b0;
        end else begin
            r_exc_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_mem_addr <= w_vec_addr;
                        r_cnt      <= '0;
                        r_state    <= ST_ISSUE;
                    end else begin
                        r_mem_addr <= w_mux_addr;
                        r_exc_err  <= exc_req;    // only reachable with a bad cause
                        r_state    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!w_last) begin
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_handler <= w_asm_word;
                    r_state   <= ST_DONE;
                end
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign handler_addr = r_handler;
    assign exc_err      = r_exc_err;
    assign busy         = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign vec_valid    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_addr_seq
// Description : Directed self-checking bench for mem_addr_seq. Instance A
//               uses default parameters (1-byte vectors at 253); instance B
//               uses 4-byte vectors at 0x100 with four causes. Each instance
//               has a byte memory returning data one cycle after the address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_addr_seq;
    import mem_addr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic [31:0] pc, alu_result, ext16, alu_out, ext25;

    logic        exc_req_a, exc_req_b;
    logic [1:0]  cause_a, cause_b;
    logic [7:0]  rdata_a = 8'h00;
    logic [7:0]  rdata_b = 8'h00;

    logic [31:0] addr_a, addr_b, handler_a, handler_b;
    logic        busy_a, busy_b, valid_a, valid_b, err_a, err_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_addr_seq u_dut_a (
        .clk(clk), .reset(reset), .sel(sel),
        .pc(pc), .alu_result(alu_result), .ext16(ext16), .alu_out(alu_out), .ext25(ext25),
        .exc_req(exc_req_a), .exc_cause(cause_a), .mem_rdata(rdata_a),
        .mem_addr(addr_a), .busy(busy_a), .vec_valid(valid_a),
        .handler_addr(handler_a), .exc_err(err_a)
    );

    mem_addr_seq #(
        .ADDR_W(32), .VEC_BASE(32'h100), .NUM_VEC(4), .VEC_BYTES(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .sel(sel),
        .pc(pc), .alu_result(alu_result), .ext16(ext16), .alu_out(alu_out), .ext25(ext25),
        .exc_req(exc_req_b), .exc_cause(cause_b), .mem_rdata(rdata_b),
        .mem_addr(addr_b), .busy(busy_b), .vec_valid(valid_b),
        .handler_addr(handler_b), .exc_err(err_b)
    );

    function automatic logic [7:0] mem_a(input logic [31:0] a);
        case (a)
            32'd253: return 8'h5A;
            32'd254: return 8'h3C;
            32'd255: return 8'h7C;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic logic [7:0] mem_b(input logic [31:0] a);
        case (a)
            32'h100: return 8'hA0;  32'h101: return 8'hA1;
            32'h102: return 8'hA2;  32'h103: return 8'hA3;
            32'h104: return 8'h11;  32'h105: return 8'h22;
            32'h106: return 8'h33;  32'h107: return 8'h44;
            32'h108: return 8'h55;  32'h109: return 8'h66;
            32'h10A: return 8'h77;  32'h10B: return 8'h88;
            32'h10C: return 8'hDE;  32'h10D: return 8'hAD;
            32'h10E: return 8'hBE;  32'h10F: return 8'hEF;
            default: return 8'h00;
        endcase
    endfunction

    // Byte memories: address in cycle k -> data in cycle k+1.
    always @(posedge clk) begin
        rdata_a <= mem_a(addr_a);
        rdata_b <= mem_b(addr_b);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sel_val [5];
    logic [31:0] b_addr_exp [7];
    int          pulses;
    logic        saw_valid;

    initial begin
        reset = 1'b0;
        sel = SEL_PC;
        pc = 32'h400; alu_result = 32'h1111_0004; ext16 = 32'hFFFF_8000;
        alu_out = 32'h0000_2468; ext25 = 32'h01AB_CDEF;
        exc_req_a = 1'b0; exc_req_b = 1'b0; cause_a = 2'd0; cause_b = 2'd0;

        // ---------------- reset state ----------------
        tick(); tick();
        check_eq("rst_addr_a",    addr_a,    32'h0);
        check_eq("rst_busy_a",    busy_a,    32'h0);
        check_eq("rst_valid_a",   valid_a,   32'h0);
        check_eq("rst_handler_a", handler_a, 32'h0);
        check_eq("rst_err_a",     err_a,     32'h0);
        check_eq("rst_addr_b",    addr_b,    32'h0);

        // ---------------- normal select ----------------
        reset = 1'b1;
        tick();
        check_eq("sel_pc_a", addr_a, 32'h400);
        check_eq("sel_pc_b", addr_b, 32'h400);

        sel_val = '{32'h400, 32'h1111_0004, 32'hFFFF_8000, 32'h0000_2468, 32'h01AB_CDEF};
        for (int k = 1; k <= 4; k++) begin
            sel = 3'(k);
            tick();
            check_eq($sformatf("sel%0d_a", k), addr_a, sel_val[k]);
        end
        sel = 3'd6; pc = 32'h999;
        tick();
        check_eq("sel6_hold_a", addr_a, 32'h01AB_CDEF);
        check_eq("sel6_hold_b", addr_b, 32'h01AB_CDEF);

        // ---------------- default params, cause 2 ----------------
        sel = SEL_PC; pc = 32'h500;
        exc_req_a = 1'b1; cause_a = 2'd2;
        tick();                                   // cycle 1
        exc_req_a = 1'b0;
        check_eq("a2_c1_addr", addr_a, 32'd255);
        check_eq("a2_c1_busy", busy_a, 32'h1);
        check_eq("a2_c1_b_follows", addr_b, 32'h500);
        tick();                                   // cycle 2
        check_eq("a2_c2_addr_held", addr_a, 32'd255);
        check_eq("a2_c2_busy", busy_a, 32'h1);
        check_eq("a2_c2_valid", valid_a, 32'h0);
        tick();                                   // cycle 3
        check_eq("a2_c3_valid",   valid_a,   32'h1);
        check_eq("a2_c3_handler", handler_a, 32'h0000_007C);
        check_eq("a2_c3_busy",    busy_a,    32'h0);
        tick();                                   // cycle 4
        check_eq("a2_c4_valid",   valid_a,   32'h0);
        check_eq("a2_c4_handler", handler_a, 32'h0000_007C);
        check_eq("a2_c4_addr",    addr_a,    32'h500);

        // ---------------- default params, cause 3 (out of range) ----------------
        pc = 32'h800;
        exc_req_a = 1'b1; cause_a = 2'd3;
        tick();
        exc_req_a = 1'b0; pc = 32'h804;
        check_eq("a3_err",  err_a,  32'h1);
        check_eq("a3_busy", busy_a, 32'h0);
        check_eq("a3_addr", addr_a, 32'h800);
        tick();
        check_eq("a3_err_clear", err_a,  32'h0);
        check_eq("a3_addr_next", addr_a, 32'h804);
        check_eq("a3_busy_next", busy_a, 32'h0);

        // ---------------- 4-byte vectors, cause 1, ignored request ----------------
        pc = 32'h900;
        b_addr_exp = '{32'h0, 32'h104, 32'h105, 32'h106, 32'h107, 32'h107, 32'h0};
        exc_req_b = 1'b1; cause_b = 2'd1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) exc_req_b = 1'b0;
            if (c == 3) begin exc_req_b = 1'b1; cause_b = 2'd0; end
            if (c == 4) exc_req_b = 1'b0;
            if (c <= 5) check_eq($sformatf("b1_c%0d_addr", c), addr_b, b_addr_exp[c]);
            check_eq($sformatf("b1_c%0d_busy", c),  busy_b,  (c <= 5) ? 32'h1 : 32'h0);
            check_eq($sformatf("b1_c%0d_valid", c), valid_b, (c == 6) ? 32'h1 : 32'h0);
        end
        check_eq("b1_handler", handler_b, 32'h4433_2211);
        tick();
        check_eq("b1_c7_valid", valid_b, 32'h0);
        check_eq("b1_c7_err",   err_b,   32'h0);
        check_eq("b1_c7_addr",  addr_b,  32'h900);

        // ---------------- reset mid-fetch ----------------
        exc_req_b = 1'b1; cause_b = 2'd1;
        tick();
        exc_req_b = 1'b0;
        tick();                                   // cycle 2
        check_eq("abort_pre_addr", addr_b, 32'h105);
        #1 reset = 1'b0;
        #1;
        check_eq("abort_addr",    addr_b,    32'h0);
        check_eq("abort_busy",    busy_b,    32'h0);
        check_eq("abort_handler", handler_b, 32'h0);
        check_eq("abort_valid",   valid_b,   32'h0);
        tick(); tick();
        reset = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            saw_valid = saw_valid | valid_b;
        end
        check_eq("abort_no_valid", saw_valid, 32'h0);
        check_eq("abort_addr_follow", addr_b, 32'h900);

        exc_req_b = 1'b1; cause_b = 2'd3;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                exc_req_b = 1'b0;
                check_eq("b3_c1_addr", addr_b, 32'h10C);
            end
        end
        check_eq("b3_valid",   valid_b,   32'h1);
        check_eq("b3_handler", handler_b, 32'hEFBE_ADDE);

        // ---------------- back-to-back with exc_req held ----------------
        pulses = 0;
        exc_req_a = 1'b1; cause_a = 2'd0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (valid_a) pulses++;
            case (c)
                1: begin
                    check_eq("bb_c1_addr", addr_a, 32'd253);
                    check_eq("bb_c1_busy", busy_a, 32'h1);
                end
                3: begin
                    check_eq("bb_c3_valid",   valid_a,   32'h1);
                    check_eq("bb_c3_handler", handler_a, 32'h0000_005A);
                    cause_a = 2'd1;
                end
                4: begin
                    check_eq("bb_c4_addr", addr_a, 32'd254);
                    check_eq("bb_c4_busy", busy_a, 32'h1);
                    exc_req_a = 1'b0;
                end
                6: begin
                    check_eq("bb_c6_valid",   valid_a,   32'h1);
                    check_eq("bb_c6_handler", handler_a, 32'h0000_003C);
                end
                default: ;
            endcase
        end
        check_eq("bb_pulses", 32'(pulses), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_addr_seq.md
# mem_addr_seq

Parametrised, registered memory-address source for the multicycle CPU. It replaces the fixed combinational address mux, where the exception vector bytes sit at constant addresses. It selects the normal address source (PC, ALU result, extended immediates, ALU-out register). It also owns an exception-vector fetch sequencer: it walks a configurable multi-byte vector table in memory, assembles the handler address and hands it to the control unit with a valid pulse.

## Interface
- `ADDR_W`, 32, width of all address inputs/outputs.
- `VEC_BASE`, 253, byte address of vector 0.
- `NUM_VEC`, 3, number of exception causes.
- `VEC_BYTES`, 1, bytes per vector entry; legal range 1..ADDR_W/8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `sel` in 3: source select. 0 = pc, 1 = alu_result, 2 = ext16, 3 = alu_out, 4 = ext25, 5–7 reserved.
- `pc`, `alu_result`, `ext16`, `alu_out`, `ext25` in ADDR_W each: candidate addresses.
- `exc_req` in 1: start vector fetch, sampled on the clock edge.
- `exc_cause` in clog2(NUM_VEC) (min 1): vector index.
- `mem_rdata` in 8: memory byte read.
- `mem_addr` out ADDR_W: registered address to memory.
- `busy` out 1: fetch in progress.
- `vec_valid` out 1: one-cycle pulse, handler_addr newly valid.
- `handler_addr` out ADDR_W: assembled handler address, held until next fetch.
- `exc_err` out 1: one-cycle pulse, cause out of range.

## Operation
- Memory model: a byte addressed by `mem_addr` in cycle k appears on `mem_rdata` in cycle k+1.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE:
  - `mem_addr` loads mux(sel) each edge.
  - Reserved sel values hold `mem_addr`.
- `exc_req` in IDLE or DONE with `exc_cause` < NUM_VEC:
  - Load `mem_addr` = VEC_BASE + cause·VEC_BYTES, computed mod 2^ADDR_W.
  - Clear byte counter; go to ISSUE.
- `exc_req` in IDLE or DONE with `exc_cause` ≥ NUM_VEC:
  - No fetch; `exc_err` = 1 next cycle.
  - `mem_addr` follows sel normally.
- ISSUE (counter c = index of byte currently on `mem_addr`):
  - If c ≥ 1, capture `mem_rdata` as byte c−1.
  - If c < VEC_BYTES−1, `mem_addr` += 1 and c += 1; otherwise hold `mem_addr` and go to DRAIN.
- DRAIN: capture byte VEC_BYTES−1; update `handler_addr`; go to DONE.
- DONE: `vec_valid` = 1, `busy` = 0. Next state is IDLE, or ISSUE on an accepted new request (back-to-back allowed).
- Assembly is little-endian: byte 0 → bits [7:0]. Unfilled upper bits are zero.
- `busy` = 1 exactly in ISSUE and DRAIN.
- `exc_req` during busy is ignored; no error, no queueing.
- `sel` is ignored during busy.
- Reset at any time, including mid-fetch, forces:
  - State IDLE.
  - `mem_addr`, `handler_addr` = 0.
  - `busy`, `vec_valid`, `exc_err` = 0.
  - No completion pulse for the aborted fetch.

## Timing
- Normal path: 1-cycle latency, sel/data at cycle k → `mem_addr` at k+1.
- Fetch: request sampled at cycle 0.
  - Vector address byte i appears on `mem_addr` at cycle 1+i.
  - `vec_valid` appears at cycle VEC_BYTES+2.
  - `busy` covers cycles 1..VEC_BYTES+1.
- `exc_err` is asserted at cycle 1 only.

## Structure
- Shared package `mem_addr_pkg`:
  - sel encodings (SEL_PC … SEL_EXT25).
  - FSM state enum.
  - Default VEC_BASE / NUM_VEC constants.
- Sub-module `vec_assembler`: byte-lane shift/insert register of VEC_BYTES lanes, with clear, load-lane and zero-extend output.
- Sub-module is instantiated once; the FSM, counter and address register stay in the top.

## Test plan
- Reset and normal select:
  - Hold reset low → all outputs 0.
  - Release; sel=0, pc=0x400 → `mem_addr`=0x400 next cycle.
  - sel=4, ext25=0x1ABCDEF → 0x1ABCDEF.
  - sel=6 → value held.
- Default params, cause=2:
  - `mem_addr`=255 at cycle 1, `busy`=1.
  - `mem_rdata`=0x7C at cycle 2.
  - `vec_valid` at cycle 3, `handler_addr`=0x0000007C.
- VEC_BYTES=4, VEC_BASE=0x100, NUM_VEC=4, cause=1:
  - Addresses 0x104–0x107 at cycles 1–4.
  - Bytes 0x11, 0x22, 0x33, 0x44 at cycles 2–5.
  - `vec_valid` at cycle 6, `handler_addr`=0x44332211.
  - `exc_req` at cycle 3 is ignored.
- Default params, cause=3:
  - `exc_err` pulse at cycle 1.
  - `busy` stays 0; `mem_addr` follows sel.
- Reset in cycle 2 of a 4-byte fetch:
  - Immediate zeros; no `vec_valid`.
  - New request after release completes normally.
- `exc_req` held during DONE:
  - Second fetch begins; its first vector address appears the cycle after DONE.
  - `vec_valid` pulses once per fetch.
